cc_speedcounter: RTL and testbench

Upstream timebase for the speed comparator. It drives the 23-bit count bus (`CC_SPEEDCOMPARATOR_data_InBUS`) and the 2-bit level bus (`CC_NIVEL_data_InBus`) that the comparator evaluates. It consumes the comparator's active-low match `T0` to reload the count and emit a one-cycle game tick. After a fixed number of ticks it raises the level, saturating at 3, so the comparator selects progressively shorter periods.

---
 rtl/cc_speedcounter.sv | 146 ++++++++++++++
 tb/tb_cc_speedcounter.sv | 295 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cc_speedcounter.sv
// -----------------------------------------------------------------------------
// cc_speedcounter
//
// Timebase that feeds the speed comparator. It counts up on the count bus
// while running. When the comparator reports a match (active-low T0), it
// reloads the count to zero and gives a one-cycle game tick. Every
// SPEEDCOUNTER_TICKSPERLEVEL accepted matches, the level steps up. The level
// stops at 3, so the comparator selects shorter and shorter periods.
//
// Ports
//   CC_SPEEDCOUNTER_CLOCK_50          in   system clock, rising edge
//   CC_SPEEDCOUNTER_RESET_InLow       in   synchronous active-low reset
//   CC_SPEEDCOUNTER_T0_InLow          in   comparator match, active-low
//   CC_SPEEDCOUNTER_enable_InHigh     in   run (1) / pause (0)
//   CC_SPEEDCOUNTER_clear_InHigh      in   synchronous game restart
//   CC_SPEEDCOUNTER_data_OutBUS       out  registered count to comparator
//   CC_NIVEL_data_OutBus              out  registered level 0..3
//   CC_SPEEDCOUNTER_tick_OutHigh      out  one-cycle pulse per accepted T0
//   CC_SPEEDCOUNTER_maxlevel_OutHigh  out  high while level == 3
//   CC_SPEEDCOUNTER_state_OutDbg      out  FSM state (0 IDLE, 1 COUNT, 2 RELOAD)
// -----------------------------------------------------------------------------
module cc_speedcounter #(
   parameter int SPEEDCOUNTER_DATAWIDTH     = 23,
   parameter int SPEEDCOUNTER_TICKSPERLEVEL = 8
) (
   input  logic                              CC_SPEEDCOUNTER_CLOCK_50,
   input  logic                              CC_SPEEDCOUNTER_RESET_InLow,
   input  logic                              CC_SPEEDCOUNTER_T0_InLow,
   input  logic                              CC_SPEEDCOUNTER_enable_InHigh,
   input  logic                              CC_SPEEDCOUNTER_clear_InHigh,
   output logic [SPEEDCOUNTER_DATAWIDTH-1:0] CC_SPEEDCOUNTER_data_OutBUS,
   output logic [1:0]                        CC_NIVEL_data_OutBus,
   output logic                              CC_SPEEDCOUNTER_tick_OutHigh,
   output logic                              CC_SPEEDCOUNTER_maxlevel_OutHigh,
   output logic [1:0]                        CC_SPEEDCOUNTER_state_OutDbg
);

   localparam int DW    = SPEEDCOUNTER_DATAWIDTH;
   localparam int TPL   = SPEEDCOUNTER_TICKSPERLEVEL;
   localparam int EVT_W = (TPL > 1) ? $clog2(TPL) : 1;

   localparam logic [DW-1:0]    CNT_ONE  = DW'(1);
   localparam logic [EVT_W-1:0] EVT_ONE  = EVT_W'(1);
   localparam logic [EVT_W-1:0] EVT_LAST = EVT_W'(TPL - 1);
   localparam logic [1:0]       LVL_MAX  = 2'd3;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_COUNT  = 2'd1,
      ST_RELOAD = 2'd2
   } state_t;

   state_t           state_q, state_d;
   logic [DW-1:0]    count_q, count_d;
   logic [1:0]       level_q, level_d;
   logic [EVT_W-1:0] evt_q, evt_d;
   logic             tick_q, tick_d;
   logic             maxlevel_q, maxlevel_d;

   // Next-state logic. Clear has priority over everything except reset.
   // In COUNT, a T0 match has priority over enable: a match seen in the
   // same cycle as a pause still reloads, and RELOAD then goes to IDLE.
   always_comb begin
      state_d = state_q;
      count_d = count_q;
      level_d = level_q;
      evt_d   = evt_q;

      if (CC_SPEEDCOUNTER_clear_InHigh) begin
         state_d = ST_IDLE;
         count_d = '0;
         level_d = 2'd0;
         evt_d   = '0;
      end else begin
         case (state_q)
            ST_IDLE: begin
               // T0 is ignored here. A match that is still held low is
               // taken in the first COUNT cycle after resume.
               if (CC_SPEEDCOUNTER_enable_InHigh) begin
                  state_d = ST_COUNT;
               end
            end
            ST_COUNT: begin
               if (!CC_SPEEDCOUNTER_T0_InLow) begin
                  state_d = ST_RELOAD;
                  count_d = '0;
                  if (evt_q == EVT_LAST) begin
                     // The event counter keeps cycling at level 3, even
                     // though the level no longer changes.
                     evt_d = '0;
                     if (level_q != LVL_MAX) begin
                        level_d = level_q + 2'd1;
                     end
                  end else begin
                     evt_d = evt_q + EVT_ONE;
                  end
               end else if (CC_SPEEDCOUNTER_enable_InHigh) begin
                  // When the count wraps, no tick is produced. Only a
                  // comparator match makes a tick.
                  count_d = count_q + CNT_ONE;
               end else begin
                  state_d = ST_IDLE;
               end
            end
            ST_RELOAD: begin
               count_d = '0;
               state_d = CC_SPEEDCOUNTER_enable_InHigh ? ST_COUNT : ST_IDLE;
            end
            default: begin
               state_d = ST_IDLE;
               count_d = '0;
            end
         endcase
      end

      // The tick and maxlevel outputs are registered copies of the next
      // state. This keeps them in line with count and level.
      tick_d     = (state_d == ST_RELOAD);
      maxlevel_d = (level_d == LVL_MAX);
   end

   always_ff @(posedge CC_SPEEDCOUNTER_CLOCK_50) begin
      if (!CC_SPEEDCOUNTER_RESET_InLow) begin
         state_q    <= ST_IDLE;
         count_q    <= '0;
         level_q    <= 2'd0;
         evt_q      <= '0;
         tick_q     <= 1'b0;
         maxlevel_q <= 1'b0;
      end else begin
         state_q    <= state_d;
         count_q    <= count_d;
         level_q    <= level_d;
         evt_q      <= evt_d;
         tick_q     <= tick_d;
         maxlevel_q <= maxlevel_d;
      end
   end

   assign CC_SPEEDCOUNTER_data_OutBUS      = count_q;
   assign CC_NIVEL_data_OutBus             = level_q;
   assign CC_SPEEDCOUNTER_tick_OutHigh     = tick_q;
   assign CC_SPEEDCOUNTER_maxlevel_OutHigh = maxlevel_q;
   assign CC_SPEEDCOUNTER_state_OutDbg     = state_q;

endmodule

// File: tb/tb_cc_speedcounter.sv
// -----------------------------------------------------------------------------
// tb_cc_speedcounter
//
// Bench for cc_speedcounter. It uses a table of directed vectors for reset
// and reload, plus hand-written sequences for levels, pause, clear and
// reset. A small behavioural comparator with short thresholds is used to
// check the tick spacing. A second instance with a 4-bit count and 2 ticks
// per level checks wrap-around and the minimum ticks-per-level setting.
// -----------------------------------------------------------------------------
module tb_cc_speedcounter;

   localparam logic [1:0] S_IDLE = 2'd0, S_COUNT = 2'd1, S_RELOAD = 2'd2;

   // ---------------- clock / reset ----------------
   logic clk;
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   logic        rst_n, en, clr, t0_man, use_cmp;
   logic        t0;
   logic        cmp_t0;
   logic [22:0] cnt;
   logic [1:0]  lvl, st;
   logic        tick, maxl;

   // Stand-in for the comparator. The thresholds are shortened so the
   // bench stays fast.
   function automatic logic [22:0] thr_f(input logic [1:0] l);
      case (l)
         2'd0:    thr_f = 23'd40;
         2'd1:    thr_f = 23'd20;
         2'd2:    thr_f = 23'd19;
         default: thr_f = 23'd10;
      endcase
   endfunction

   assign cmp_t0 = (cnt == thr_f(lvl)) ? 1'b0 : 1'b1;
   assign t0     = use_cmp ? cmp_t0 : t0_man;

   cc_speedcounter #(
      .SPEEDCOUNTER_DATAWIDTH    (23),
      .SPEEDCOUNTER_TICKSPERLEVEL(8)
   ) dut (
      .CC_SPEEDCOUNTER_CLOCK_50        (clk),
      .CC_SPEEDCOUNTER_RESET_InLow     (rst_n),
      .CC_SPEEDCOUNTER_T0_InLow        (t0),
      .CC_SPEEDCOUNTER_enable_InHigh   (en),
      .CC_SPEEDCOUNTER_clear_InHigh    (clr),
      .CC_SPEEDCOUNTER_data_OutBUS     (cnt),
      .CC_NIVEL_data_OutBus            (lvl),
      .CC_SPEEDCOUNTER_tick_OutHigh    (tick),
      .CC_SPEEDCOUNTER_maxlevel_OutHigh(maxl),
      .CC_SPEEDCOUNTER_state_OutDbg    (st)
   );

   logic       w_rst_n, w_en, w_clr, w_t0;
   logic [3:0] w_cnt;
   logic [1:0] w_lvl, w_st;
   logic       w_tick, w_maxl;

   cc_speedcounter #(
      .SPEEDCOUNTER_DATAWIDTH    (4),
      .SPEEDCOUNTER_TICKSPERLEVEL(2)
   ) dut_w (
      .CC_SPEEDCOUNTER_CLOCK_50        (clk),
      .CC_SPEEDCOUNTER_RESET_InLow     (w_rst_n),
      .CC_SPEEDCOUNTER_T0_InLow        (w_t0),
      .CC_SPEEDCOUNTER_enable_InHigh   (w_en),
      .CC_SPEEDCOUNTER_clear_InHigh    (w_clr),
      .CC_SPEEDCOUNTER_data_OutBUS     (w_cnt),
      .CC_NIVEL_data_OutBus            (w_lvl),
      .CC_SPEEDCOUNTER_tick_OutHigh    (w_tick),
      .CC_SPEEDCOUNTER_maxlevel_OutHigh(w_maxl),
      .CC_SPEEDCOUNTER_state_OutDbg    (w_st)
   );

   // ---------------- scoreboard ----------------
   int          errors = 0;
   int          checks = 0;
   logic [31:0] exp_q[$];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
      end
   endtask

   // ---------------- driver tasks ----------------
   // Inputs change 1 time unit after the rising edge. Outputs are read at
   // that same point.
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic check_all(input logic [22:0] c, input logic [1:0] l,
                            input logic tk, input logic mx, input logic [1:0] s);
      check("count", {9'd0, cnt}, {9'd0, c});
      check("level", {30'd0, lvl}, {30'd0, l});
      check("tick", {31'd0, tick}, {31'd0, tk});
      check("maxlevel", {31'd0, maxl}, {31'd0, mx});
      check("state", {30'd0, st}, {30'd0, s});
   endtask

   task automatic wait_count(input logic [22:0] target, input int budget);
      int n;
      n = 0;
      while (cnt != target && n < budget) begin
         step();
         n++;
      end
      check("wait_count", {9'd0, cnt}, {9'd0, target});
   endtask

   int ev_model;

   function automatic logic [1:0] lvl_model(input int ev);
      lvl_model = (ev / 8 >= 3) ? 2'd3 : 2'(ev / 8);
   endfunction

   // One accepted match at count 3, then one following COUNT cycle.
   task automatic do_event();
      en     = 1'b1;
      t0_man = 1'b1;
      wait_count(23'd3, 20);
      t0_man = 1'b0;
      step();
      ev_model++;
      check_all(23'd0, lvl_model(ev_model), 1'b1, (lvl_model(ev_model) == 2'd3), S_RELOAD);
      t0_man = 1'b1;
      step();
      check("tick_one_cycle", {31'd0, tick}, 32'd0);
   endtask

   // ---------------- vector table ----------------
   typedef struct {
      logic        rst_n, en, clr, t0;
      logic [22:0] cnt;
      logic [1:0]  lvl;
      logic        tick, maxl;
      logic [1:0]  st;
   } vec_t;

   vec_t vecs[13];

   initial begin
      #4_000_000;
      $display("FAIL watchdog: got timeout, expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      int cyc, last_cyc, tick_no, n;
      logic [1:0] lvl_prev;

      // Reset held 3 cycles with enable=1 and T0=0, then a reload at count 5.
      vecs[0]  = '{1'b0, 1'b1, 1'b0, 1'b0, 23'd0, 2'd0, 1'b0, 1'b0, S_IDLE};
      vecs[1]  = '{1'b0, 1'b1, 1'b0, 1'b0, 23'd0, 2'd0, 1'b0, 1'b0, S_IDLE};
      vecs[2]  = '{1'b0, 1'b1, 1'b0, 1'b0, 23'd0, 2'd0, 1'b0, 1'b0, S_IDLE};
      vecs[3]  = '{1'b1, 1'b1, 1'b0, 1'b1, 23'd0, 2'd0, 1'b0, 1'b0, S_COUNT};
      vecs[4]  = '{1'b1, 1'b1, 1'b0, 1'b1, 23'd1, 2'd0, 1'b0, 1'b0, S_COUNT};
      vecs[5]  = '{1'b1, 1'b1, 1'b0, 1'b1, 23'd2, 2'd0, 1'b0, 1'b0, S_COUNT};
      vecs[6]  = '{1'b1, 1'b1, 1'b0, 1'b1, 23'd3, 2'd0, 1'b0, 1'b0, S_COUNT};
      vecs[7]  = '{1'b1, 1'b1, 1'b0, 1'b1, 23'd4, 2'd0, 1'b0, 1'b0, S_COUNT};
      vecs[8]  = '{1'b1, 1'b1, 1'b0, 1'b1, 23'd5, 2'd0, 1'b0, 1'b0, S_COUNT};
      vecs[9]  = '{1'b1, 1'b1, 1'b0, 1'b0, 23'd0, 2'd0, 1'b1, 1'b0, S_RELOAD};
      vecs[10] = '{1'b1, 1'b1, 1'b0, 1'b1, 23'd0, 2'd0, 1'b0, 1'b0, S_COUNT};
      vecs[11] = '{1'b1, 1'b1, 1'b0, 1'b1, 23'd1, 2'd0, 1'b0, 1'b0, S_COUNT};
      vecs[12] = '{1'b1, 1'b1, 1'b0, 1'b1, 23'd2, 2'd0, 1'b0, 1'b0, S_COUNT};

      use_cmp = 1'b0;
      w_rst_n = 1'b0; w_en = 1'b0; w_clr = 1'b0; w_t0 = 1'b1;

      for (int i = 0; i < 13; i++) begin
         rst_n  = vecs[i].rst_n;
         en     = vecs[i].en;
         clr    = vecs[i].clr;
         t0_man = vecs[i].t0;
         step();
         check_all(vecs[i].cnt, vecs[i].lvl, vecs[i].tick, vecs[i].maxl, vecs[i].st);
      end
      ev_model = 1;

      // Levels: repeated matches at count 3, ending 16 ticks past level 3.
      while (ev_model < 40) do_event();

      // Pause at count 100. T0 is held low during the pause.
      wait_count(23'd100, 200);
      en = 1'b0;
      step();
      check_all(23'd100, 2'd3, 1'b0, 1'b1, S_IDLE);
      t0_man = 1'b0;
      for (int i = 0; i < 9; i++) begin
         step();
         check("pause_count", {9'd0, cnt}, 32'd100);
         check("pause_tick", {31'd0, tick}, 32'd0);
      end
      en = 1'b1;
      step();
      check_all(23'd100, 2'd3, 1'b0, 1'b1, S_COUNT);
      step();
      check_all(23'd0, 2'd3, 1'b1, 1'b1, S_RELOAD);

      // A T0 match beats enable=0 in the same cycle, then RELOAD goes to IDLE.
      t0_man = 1'b1;
      step();
      check("resume_state", {30'd0, st}, {30'd0, S_COUNT});
      en = 1'b0; t0_man = 1'b0;
      step();
      check_all(23'd0, 2'd3, 1'b1, 1'b1, S_RELOAD);
      t0_man = 1'b1;
      step();
      check_all(23'd0, 2'd3, 1'b0, 1'b1, S_IDLE);

      // Clear on its own, then climb to level 2, then clear with T0 in the same cycle.
      clr = 1'b1;
      step();
      check_all(23'd0, 2'd0, 1'b0, 1'b0, S_IDLE);
      clr = 1'b0;
      ev_model = 0;
      for (int i = 0; i < 16; i++) do_event();
      check("at_level2", {30'd0, lvl}, 32'd2);
      clr = 1'b1; t0_man = 1'b0;
      step();
      check_all(23'd0, 2'd0, 1'b0, 1'b0, S_IDLE);
      clr = 1'b0; t0_man = 1'b1;

      // Reset in the middle of a period.
      en = 1'b1;
      wait_count(23'd7, 20);
      rst_n = 1'b0;
      step();
      check_all(23'd0, 2'd0, 1'b0, 1'b0, S_IDLE);
      rst_n = 1'b1;

      // Integration with the behavioural comparator: check every tick gap.
      clr = 1'b1;
      step();
      clr = 1'b0;
      use_cmp = 1'b1;
      en = 1'b1;
      cyc = 0; last_cyc = 0; tick_no = 0;
      while (tick_no < 30 && cyc < 3000) begin
         step();
         cyc++;
         if (tick === 1'b1) begin
            tick_no++;
            lvl_prev = lvl_model(tick_no);
            check("tick_level", {30'd0, lvl}, {30'd0, lvl_prev});
            if (tick_no >= 2) begin
               check("tick_gap", cyc - last_cyc, exp_q.pop_front());
            end
            exp_q.push_back({9'd0, thr_f(lvl_prev)} + 32'd2);
            last_cyc = cyc;
         end
      end
      check("tick_total", tick_no, 30);
      use_cmp = 1'b0;

      // 4-bit instance: the count wraps with no tick, and the level steps after 2 matches.
      w_rst_n = 1'b0;
      step();
      w_rst_n = 1'b1; w_en = 1'b1; w_t0 = 1'b1;
      step();
      n = 0;
      while (w_cnt != 4'd15 && n < 40) begin
         step();
         n++;
      end
      check("w_at15", {28'd0, w_cnt}, 32'd15);
      step();
      check("w_wrap_count", {28'd0, w_cnt}, 32'd0);
      check("w_wrap_tick", {31'd0, w_tick}, 32'd0);
      w_t0 = 1'b0;
      step();
      check("w_tick1", {31'd0, w_tick}, 32'd1);
      check("w_lvl_after1", {30'd0, w_lvl}, 32'd0);
      w_t0 = 1'b1;
      step();
      w_t0 = 1'b0;
      step();
      check("w_tick2", {31'd0, w_tick}, 32'd1);
      check("w_lvl_after2", {30'd0, w_lvl}, 32'd1);
      w_t0 = 1'b1;
      step();

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
